// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: Q3.13 angle in, Q3.13 cosine/sine out.
// One micro-rotation per clock under a start/busy/done handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   start    request, sampled only while busy=0
//   angle_in signed Q3.13 angle (radians), clamped to +/-pi
//   busy     high while an operation is in progress
//   done     one-cycle pulse, results valid and held until next done
//   cos_out  signed Q3.13 cosine
//   sin_out  signed Q3.13 sine
module cordic_sincos #(
   parameter int ITERATIONS = 12,
   parameter int XY_W       = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [15:0] angle_in,
   output logic               busy,
   output logic               done,
   output logic signed [15:0] cos_out,
   output logic signed [15:0] sin_out
);

   localparam int ZW = 17;
   localparam int CW = 5;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   localparam logic signed [ZW-1:0]   PI     = ZW'(25736);
   localparam logic signed [ZW-1:0]   PI_2   = ZW'(12868);
   localparam logic signed [XY_W-1:0] K_SEED = XY_W'(4975);
   localparam logic signed [XY_W-1:0] SMAX   = XY_W'(32767);
   localparam logic signed [XY_W-1:0] SMIN   = -XY_W'(32768);

   function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
      logic signed [ZW-1:0] r;
      case (idx)
         5'd0:    r = ZW'(6434);
         5'd1:    r = ZW'(3798);
         5'd2:    r = ZW'(2007);
         5'd3:    r = ZW'(1019);
         5'd4:    r = ZW'(511);
         5'd5:    r = ZW'(256);
         5'd6:    r = ZW'(128);
         5'd7:    r = ZW'(64);
         5'd8:    r = ZW'(32);
         5'd9:    r = ZW'(16);
         5'd10:   r = ZW'(8);
         5'd11:   r = ZW'(4);
         5'd12:   r = ZW'(2);
         5'd13:   r = ZW'(1);
         5'd14:   r = ZW'(1);
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [XY_W-1:0] v);
      logic signed [15:0] r;
      if (v > SMAX)      r = 16'sh7fff;
      else if (v < SMIN) r = 16'sh8000;
      else               r = v[15:0];
      return r;
   endfunction

   logic [1:0]               state_q, state_d;
   logic signed [XY_W-1:0]   x_q, x_d, y_q, y_d;
   logic signed [ZW-1:0]     z_q, z_d;
   logic [CW-1:0]            i_q, i_d;
   logic                     neg_q, neg_d;
   logic                     done_q, done_d;
   logic signed [15:0]       cos_q, cos_d, sin_q, sin_d;

   logic signed [ZW-1:0]     ang_ext, ang_c, z0;
   logic                     neg0;
   logic signed [XY_W-1:0]   xs, ys, xn, yn;
   logic signed [ZW-1:0]     at;

   // Clamp to +/-pi, then fold outer half-planes onto the inner one;
   // the fold by pi is undone later by negating both results.
   always_comb begin
      ang_ext = {angle_in[15], angle_in};
      if (ang_ext > PI)       ang_c = PI;
      else if (ang_ext < -PI) ang_c = -PI;
      else                    ang_c = ang_ext;
      if (ang_c > PI_2) begin
         z0   = ang_c - PI;
         neg0 = 1'b1;
      end else if (ang_c < -PI_2) begin
         z0   = ang_c + PI;
         neg0 = 1'b1;
      end else begin
         z0   = ang_c;
         neg0 = 1'b0;
      end
   end

   assign xs = x_q >>> i_q;
   assign ys = y_q >>> i_q;
   assign at = atan_lut(i_q);
   assign xn = neg_q ? -x_q : x_q;
   assign yn = neg_q ? -y_q : y_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      cos_d   = cos_q;
      sin_d   = sin_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               z_d     = z0;
               neg_d   = neg0;
               x_d     = K_SEED;
               y_d     = '0;
               i_d     = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (!z_q[ZW-1]) begin
               x_d = x_q - ys;
               y_d = y_q + xs;
               z_d = z_q - at;
            end else begin
               x_d = x_q + ys;
               y_d = y_q - xs;
               z_d = z_q + at;
            end
            i_d = i_q + 1'b1;
            if (i_q == CW'(ITERATIONS - 1)) state_d = S_OUT;
         end
         S_OUT: begin
            cos_d   = sat16(xn);
            sin_d   = sat16(yn);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
         cos_q   <= '0;
         sin_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign cos_out = cos_q;
   assign sin_out = sin_q;

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
Iterative CORDIC in rotation mode, the inverse of the vectoring-mode arctangent block: takes a Q3.13 angle and produces Q3.13 cosine and sine. Sits beside cordic_atan in the angle-math datapath. It performs one micro-rotation per clock under a start/busy/done handshake, so one shared shift/add datapath serves all iterations.

Parameters:
ITERATIONS, 12, number of micro-rotations (1..16); sets latency and precision
XY_W, 18, internal x/y datapath width (two guard bits above the 16-bit I/O)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
start  input  1  request; sampled only while busy=0
angle_in  input  16  signed Q3.13 angle in radians
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; cos_out/sin_out valid and held until the next done
cos_out  output  16  signed Q3.13 cosine
sin_out  output  16  signed Q3.13 sine

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; busy=0, done=0, cos_out=0, sin_out=0, iteration counter=0. Reset overrides everything, including a mid-operation sequence, which is abandoned with no done pulse.
- Angle table (Q3.13, i=0..11): 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4. For i>=12, use 2^(13-i) rounded, minimum 0.
- Gain seed: K = 4975 (0.607253 in Q3.13), valid for ITERATIONS=12. Other ITERATIONS values need the matching K constant.
- Input conditioning: angle_in is clamped to [-25736, +25736] (±pi).
  - If the clamped angle > 12868 (pi/2): z0 = angle - 25736, neg=1.
  - If it < -12868: z0 = angle + 25736, neg=1.
  - Otherwise z0 = angle, neg=0.
- States:
  - IDLE: busy=0. On start=1, latch z=z0 and neg; set x=K, y=0 (sign-extended to XY_W); i=0; go to ITER.
  - ITER: busy=1. Per cycle, d=+1 if z>=0, else -1:
    - x <= x - d*(y>>>i)
    - y <= y + d*(x>>>i)
    - z <= z - d*atan[i]
    - Shifts are arithmetic and use old x/y/z, i.e. a true simultaneous update.
    - Increment i. After the cycle with i=ITERATIONS-1, go to OUT.
  - OUT: busy=1. If neg, negate x/y. Saturate to [-32768, 32767] into cos_out/sin_out. done=1 for this one cycle. Return to IDLE.
- Timing:
  - If start is sampled at edge E0, done is high for exactly the cycle after edge E0+ITERATIONS+1 (edge 13 for the default).
  - busy is high after E0 through the OUT cycle and low in the cycle where done=1.
  - A start in the done-high cycle is accepted; back-to-back throughput is ITERATIONS+2 cycles.
- start while busy=1 is ignored; angle_in is not re-sampled mid-operation.
- cos_out/sin_out change only on a done pulse (or reset).
- Accuracy: |error| <= 8 LSB vs ideal for any angle in ±pi.

Test Plan:
- Reset: hold rst=0 for 2 clocks with start=1 -> busy=0, done=0, cos_out=0, sin_out=0. After release with angle_in=0 held, the first done appears 13 cycles after the start edge.
- Cardinal angles:
  - angle_in=0 -> cos_out=8192±8, sin_out=0±8.
  - 12868 -> cos 0±8, sin 8192±8.
  - -12868 -> cos 0±8, sin -8192±8.
- Quadrant fold:
  - 25736 -> cos -8192±8, sin 0±8.
  - 19302 (3pi/4) -> cos -5793±8, sin 5793±8.
  - 32767 (clamped) -> same result as 25736.
- Diagonal: 6434 -> cos 5793±8, sin 5793±8; done is high for exactly 1 cycle and busy=0 in that cycle.
- Handshake:
  - start=1 again at cycles +3 and +7 with different angle_in -> ignored; the first result is unchanged.
  - start=1 in the done cycle -> second result after a further 13 cycles.
- Mid-op reset: rst=0 for 1 cycle at iteration 5 -> no done pulse, outputs 0, state IDLE; a subsequent start completes normally.
